fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

- Read-side consumer for the team's `ring_fifo` / `shift_fifo`.
- Pops one word from the FIFO output port whenever one is available and serialises it onto a single UART-style line: start bit, data LSB first, optional parity, stop bit(s).
- Sits between a FIFO's `read`/`out`/`val` port and an off-chip or board-level serial pin.

## Interface
- `DATA_W`, 8: data bits per frame and FIFO word width.
- `CLK_DIV`, 16: clock cycles per serial bit; legal range ≥ 2.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `val`  in  1  FIFO has valid data on `data` (first-word-fall-through).
- `data`  in  DATA_W  FIFO head word (FIFO `out`).
- `read`  out  1  pop strobe to FIFO; the FIFO advances at the edge where `read && val`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - `read = val`, combinational.
  - If `val`, `data` is latched into the shift register at the edge and the FSM moves to START.
- START:
  - `tx = 0` for CLK_DIV cycles, then DATA.
- DATA:
  - `tx` = shift register bit 0; the register shifts right every CLK_DIV cycles.
  - After DATA_W bits the FSM moves to PARITY if the macro is defined, otherwise to STOP.
- PARITY:
  - `tx` = even parity (XOR of the latched word) for CLK_DIV cycles, then STOP.
- STOP:
  - `tx = 1` for STOP_BITS×CLK_DIV cycles.
  - In the final cycle of the final stop bit, `read = val`.
  - If `val`, the next word is latched and the FSM goes straight to START, so there is no idle gap. Otherwise it returns to IDLE.
- `read` is never asserted outside the two cases above; exactly one pop per frame.
- Counter widths:
  - Baud counter: `$clog2(CLK_DIV)` bits, counts 0..CLK_DIV-1 and wraps.
  - Bit counter: `$clog2(DATA_W+1)` bits.
  - Stop counter: 1 bit.
- `data` is sampled only at the pop edge; later changes on `data` do not affect the frame in flight.

## Timing
- Reset values, applied immediately when `rst` is low: `tx=1`, `busy=0`, `read=0`, FSM in IDLE, all counters 0, shift register 0.
- Latency: with `val` rising in cycle n while in IDLE, `read=1` in cycle n, and `tx=0` and `busy=1` from cycle n+1.
- Frame length: (1 + DATA_W + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with parity and 0 without.
- Back-to-back words: consecutive frames are contiguous on `tx`.
- `busy` drops only on the cycle the FSM actually enters IDLE.
- Empty FIFO (`val=0`) in IDLE: `tx` stays 1 and `read` stays 0 indefinitely.
- Reset mid-frame:
  - `tx` returns to 1 asynchronously and the frame is abandoned.
  - The word already popped is lost; it is not re-read after reset.
- `val` deasserting mid-frame has no effect on the current frame.

## Configuration
- `FIFO_UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in and one even-parity bit follows the data bits.
  - Undefined: the PARITY state and its logic are absent, and STOP follows DATA directly.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - `PARITY_BITS` constant, derived from the macro.
  - Frame-length helper function, used by both the RTL and the bench.
- Sub-module `baud_gen`:
  - CLK_DIV counter with a synchronous restart input.
  - Produces a one-cycle `bit_end` pulse in the last cycle of each bit period.
  - The FSM advances only on `bit_end`.

## Test plan
Benches use CLK_DIV=4 and an FWFT FIFO model unless stated otherwise.
- **Single word:** load 0xA5, no parity, STOP_BITS=1.
  - `tx` shows 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
  - One `read` pulse; `busy` high for exactly 40 cycles.
- **Back-to-back:** preload 0x00 and 0xFF.
  - Two `read` pulses 40 cycles apart.
  - `tx` is never high between the first frame's stop bit and the second frame's start bit; 80 busy cycles in total.
- **Empty FIFO:** hold `val=0` for 200 cycles.
  - `tx=1`, `read=0` and `busy=0` throughout.
- **Parity, with `FIFO_UART_TX_PARITY_EN`:** send 0x07.
  - Parity bit = 1; frame is 11 bits = 44 cycles.
  - Send 0x03: parity bit = 0.
- **STOP_BITS=2:** send 0x5A.
  - Stop level lasts 8 cycles; frame is 44 cycles.
- **Reset mid-frame:** pull `rst` low during DATA bit 3 of 0xC3.
  - `tx=1` and `busy=0` immediately.
  - After release with the FIFO holding 0x11, the next frame carries 0x11, not 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Optional even-parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
package uart_pkg;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clk_div,
                                                 input int unsigned stop_bits);
        return (1 + data_w + PARITY_BITS + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: free-running modulo-CLK_DIV counter with synchronous restart.
module baud_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FWFT FIFO read-side consumer that serialises each popped word as a UART frame.
// Build option: FIFO_UART_TX_PARITY_EN adds one even-parity bit after the data.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              val,
    input  logic [DATA_W-1:0] data,
    output logic              read,
    output logic              tx,
    output logic              busy
);
    localparam int unsigned BW           = $clog2(DATA_W + 1);
    localparam int unsigned FRAME_CYCLES = frame_cycles(DATA_W, CLK_DIV, STOP_BITS);

    if (CLK_DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || FRAME_CYCLES < 3 * CLK_DIV) begin : g_bad_cfg
        $error("fifo_uart_tx: illegal CLK_DIV/STOP_BITS configuration");
    end

    tx_state_e         state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              bit_end;
    logic              last_stop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par;
`endif

    baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state == ST_IDLE),
        .bit_end (bit_end)
    );

    assign sh_next   = shreg >> 1;
    assign last_stop = (state == ST_STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
    // Pop strobe: idle with data waiting, or the very last stop-bit cycle.
    assign read      = rst && val && ((state == ST_IDLE) || last_stop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (val) begin
                        shreg <= data;
`ifdef FIFO_UART_TX_PARITY_EN
                        par   <= ^data;
`endif
                        state <= ST_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg <= sh_next;
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            state   <= ST_PARITY;
                            tx      <= par;
`else
                            state    <= ST_STOP;
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx      <= sh_next[0];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state    <= ST_STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    if (last_stop) begin
                        stop_cnt <= 1'b0;
                        if (val) begin
                            // Chain straight into the next frame with no idle gap.
                            shreg <= data;
`ifdef FIFO_UART_TX_PARITY_EN
                            par   <= ^data;
`endif
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (bit_end) begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench: two transmitters (1 and 2 stop bits) fed by FWFT FIFO models,
// compared cycle by cycle against a frame-level reference of the serial line.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CLK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       val_w  [2];
    logic [7:0] data_w [2];
    logic       rd_w   [2];
    logic       tx_w   [2];
    logic       busy_w [2];

    logic [7:0] mem [2][256];
    logic [7:0] rp  [2];
    logic [7:0] wp  [2];

    int total;
    int bad;

    // Reference model state per instance
    bit         in_frame [2];
    int         k_m      [2];
    logic [7:0] word_m   [2];
    int         busy_cnt [2];
    int         read_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fifo_uart_tx #(
            .DATA_W    (DATA_W),
            .CLK_DIV   (CLK_DIV),
            .STOP_BITS (32'(g + 1))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .val  (val_w[g]),
            .data (data_w[g]),
            .read (rd_w[g]),
            .tx   (tx_w[g]),
            .busy (busy_w[g])
        );
        assign val_w[g]  = (rp[g] != wp[g]);
        assign data_w[g] = mem[g][rp[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= int'(DATA_W)) return w[3'(b - 1)];
        if (PARITY_BITS == 1 && b == int'(DATA_W) + 1) return ^w;
        return 1'b1;
    endfunction

    // FWFT FIFO pop side
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++)
            if (rd_w[g] && val_w[g]) rp[g] <= rp[g] + 8'd1;
    end

    // Reference comparison, sampled on the falling edge
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                check($sformatf("rst_tx%0d", g), 32'(tx_w[g]), 32'd1);
                check($sformatf("rst_busy%0d", g), 32'(busy_w[g]), 32'd0);
                check($sformatf("rst_read%0d", g), 32'(rd_w[g]), 32'd0);
                in_frame[g] = 1'b0;
                k_m[g]      = 0;
            end else begin
                int   len;
                logic etx;
                logic ebusy;
                logic eread;
                logic last;
                len = int'(frame_cycles(DATA_W, CLK_DIV, 32'(g + 1)));
                if (in_frame[g]) begin
                    etx   = exp_bit(word_m[g], k_m[g] / int'(CLK_DIV));
                    ebusy = 1'b1;
                    last  = (k_m[g] == len - 1);
                    eread = last && val_w[g];
                end else begin
                    etx   = 1'b1;
                    ebusy = 1'b0;
                    last  = 1'b1;
                    eread = val_w[g];
                end
                check($sformatf("tx%0d", g), 32'(tx_w[g]), 32'(etx));
                check($sformatf("busy%0d", g), 32'(busy_w[g]), 32'(ebusy));
                check($sformatf("read%0d", g), 32'(rd_w[g]), 32'(eread));
                if (busy_w[g]) busy_cnt[g]++;
                if (rd_w[g] && val_w[g]) read_cnt[g]++;
                if (eread) begin
                    word_m[g]   = data_w[g];
                    in_frame[g] = 1'b1;
                    k_m[g]      = 0;
                end else if (in_frame[g]) begin
                    if (last) in_frame[g] = 1'b0;
                    else      k_m[g]++;
                end
            end
        end
    end

    task automatic push(input logic [7:0] w);
        for (int g = 0; g < 2; g++) begin
            mem[g][wp[g]] = w;
            wp[g]         = wp[g] + 8'd1;
        end
    endtask

    task automatic clear_counts();
        for (int g = 0; g < 2; g++) begin
            busy_cnt[g] = 0;
            read_cnt[g] = 0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (rp[0] == wp[0]) && (rp[1] == wp[1]) && !in_frame[0] && !in_frame[1];
        end
        check("drain_timeout", 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_counts(input string tag, input int frames);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_busy_cycles%0d", tag, g), 32'(busy_cnt[g]),
                  32'(frames) * frame_cycles(DATA_W, CLK_DIV, 32'(g + 1)));
            check($sformatf("%s_reads%0d", tag, g), 32'(read_cnt[g]), 32'(frames));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int g = 0; g < 2; g++) begin
            rp[g]       = '0;
            wp[g]       = '0;
            in_frame[g] = 1'b0;
            k_m[g]      = 0;
            word_m[g]   = '0;
        end
        clear_counts();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Single word
        @(posedge clk); #2;
        clear_counts();
        push(8'hA5);
        wait_idle();
        check_counts("single", 1);

        // Back-to-back words
        clear_counts();
        push(8'h00);
        push(8'hFF);
        wait_idle();
        check_counts("b2b", 2);

        // Empty FIFO
        clear_counts();
        repeat (200) @(posedge clk);
        #2;
        check_counts("empty", 0);

        // Parity-sensitive words and a two-stop-bit pattern
        clear_counts();
        push(8'h07);
        wait_idle();
        push(8'h03);
        wait_idle();
        push(8'h5A);
        wait_idle();
        check_counts("par", 3);

        // Reset during data bit 3
        push(8'hC3);
        repeat (18) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("midrst_tx%0d", g), 32'(tx_w[g]), 32'd1);
            check($sformatf("midrst_busy%0d", g), 32'(busy_w[g]), 32'd0);
        end
        push(8'h11);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        clear_counts();
        wait_idle();
        check_counts("after_rst", 1);

        // Random traffic with random gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #2;
            push(8'($urandom));
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
        end
        wait_idle();

        for (int g = 0; g < 2; g++) begin
            check($sformatf("all_popped%0d", g), 32'(rp[g]), 32'(wp[g]));
            check($sformatf("end_busy%0d", g), 32'(busy_w[g]), 32'd0);
            check($sformatf("end_tx%0d", g), 32'(tx_w[g]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
